// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS EX/MEM pipeline: branch encodings,
// occupancy states and the packed EX/MEM bundle width.
package mips_pipe_pkg;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_JMP = 2'b10;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // zeroflag, branch, mem_to_reg, reg_write, mem_read, mem_write
    localparam int CTRL_W = 6;

    function automatic int bundle_w(int addr_w, int data_w, int reg_w);
        return addr_w + 2 * data_w + reg_w + CTRL_W;
    endfunction

    // Reserved type 2'b11 is never taken.
    function automatic logic br_taken(logic branch, logic [1:0] btype, logic zf);
        case (btype)
            BR_BEQ:  return branch & zf;
            BR_BNE:  return branch & ~zf;
            BR_JMP:  return branch;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// EX/MEM stage bus: EX-side beat, MEM-side registered copy, freeze and flush.
// master = EX/MEM environment, slave = the pipeline stage.
interface ex_mem_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    logic              hit;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] branch_target;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data_2;
    logic [REG_W-1:0]  write_reg;
    logic              branch;
    logic [1:0]        branch_type;
    logic              zeroflag;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] branch_target_out;
    logic [DATA_W-1:0] alu_result_out;
    logic [DATA_W-1:0] read_data_2_out;
    logic [REG_W-1:0]  write_reg_out;
    logic              zeroflag_out;
    logic              branch_out;
    logic              mem_to_reg_out;
    logic              reg_write_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic              pcsrc_ex_mem;
    logic [1:0]        occupancy;

    modport master (
        output hit, flush, in_valid, branch_target, alu_result, read_data_2,
               write_reg, branch, branch_type, zeroflag, mem_to_reg,
               reg_write, mem_read, mem_write, out_ready,
        input  in_ready, out_valid, branch_target_out, alu_result_out,
               read_data_2_out, write_reg_out, zeroflag_out, branch_out,
               mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
               pcsrc_ex_mem, occupancy
    );

    modport slave (
        input  hit, flush, in_valid, branch_target, alu_result, read_data_2,
               write_reg, branch, branch_type, zeroflag, mem_to_reg,
               reg_write, mem_read, mem_write, out_ready,
        output in_ready, out_valid, branch_target_out, alu_result_out,
               read_data_2_out, write_reg_out, zeroflag_out, branch_out,
               mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
               pcsrc_ex_mem, occupancy
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a global hold (hit = 0 freezes
// every flop) and flush. out_q is always the oldest beat.
module pipe_skid_buf import mips_pipe_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic             acc
);

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] out_q, skid_q;
    logic             rel, load_out, load_skid, promote;

    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = out_q;
    assign occupancy = state_q;
    assign acc       = in_valid & in_ready & hit & ~flush;
    assign rel       = out_valid & out_ready & hit;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        if (hit) begin
            if (flush) begin
                state_d = OCC_EMPTY;
            end else begin
                case (state_q)
                    OCC_EMPTY: if (acc) begin
                        state_d  = OCC_ONE;
                        load_out = 1'b1;
                    end
                    OCC_ONE: begin
                        if (acc && rel) begin
                            load_out = 1'b1;
                        end else if (acc) begin
                            state_d   = OCC_FULL;
                            load_skid = 1'b1;
                        end else if (rel) begin
                            state_d = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: if (rel) begin
                        state_d = OCC_ONE;
                        promote = 1'b1;
                    end
                    default: state_d = OCC_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out)
                out_q <= in_data;
            else if (promote)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= in_data;
        end
    end

    // Registered ready breaks the combinational path from out_ready to EX.
    if (SKID_EN) begin : g_skid
        logic rdy_q;
        always_ff @(posedge clk) begin
            if (!rst_n)
                rdy_q <= 1'b1;
            else if (hit)
                rdy_q <= (state_d != OCC_FULL);
        end
        assign in_ready = rdy_q;
    end else begin : g_single
        assign in_ready = ~out_valid | out_ready;
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX/MEM stage: packs the EX bundle through a skid buffer, gates the
// MEM-side write enables with out_valid and registers branch resolution.
module ex_mem_pipe_stage import mips_pipe_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    ex_mem_pipe_stage_if.slave  bus
);

    localparam int BW = bundle_w(ADDR_W, DATA_W, REG_W);

    logic [BW-1:0] in_bundle, out_bundle;
    logic          acc, out_valid;
    logic          reg_write_q, mem_read_q, mem_write_q;
    logic          pcsrc_q;

    assign in_bundle = {bus.branch_target, bus.alu_result, bus.read_data_2,
                        bus.write_reg, bus.zeroflag, bus.branch, bus.mem_to_reg,
                        bus.reg_write, bus.mem_read, bus.mem_write};

    pipe_skid_buf #(.WIDTH(BW), .SKID_EN(SKID_EN)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (bus.hit),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_bundle),
        .occupancy (bus.occupancy),
        .acc       (acc)
    );

    assign {bus.branch_target_out, bus.alu_result_out, bus.read_data_2_out,
            bus.write_reg_out, bus.zeroflag_out, bus.branch_out,
            bus.mem_to_reg_out, reg_write_q, mem_read_q, mem_write_q} = out_bundle;

    // An empty slot must never write memory or the register file.
    assign bus.out_valid     = out_valid;
    assign bus.reg_write_out = reg_write_q & out_valid;
    assign bus.mem_read_out  = mem_read_q  & out_valid;
    assign bus.mem_write_out = mem_write_q & out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n)
            pcsrc_q <= 1'b0;
        else if (bus.hit)
            pcsrc_q <= acc & br_taken(bus.branch, bus.branch_type, bus.zeroflag);
    end

    assign bus.pcsrc_ex_mem = pcsrc_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: beats are queued on acceptance and
// compared against the output entry every cycle, along with occupancy/pcsrc.
module tb_ex_mem_pipe_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_mem_pipe_stage_if #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) bus ();

    ex_mem_pipe_stage #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .SKID_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] alu, rd2, bt;
        logic [4:0]  wreg;
        logic        zf, br, m2r, regw, memr, memw;
    } beat_t;

    beat_t sb[$];
    logic  exp_pc;
    int    n_chk, n_err;
    bit    live;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tb_taken(input logic br, input logic [1:0] bt, input logic zf);
        if (!br) return 1'b0;
        if (bt == 2'b00) return zf;
        if (bt == 2'b01) return !zf;
        return (bt == 2'b10);
    endfunction

    function automatic beat_t cur_beat();
        beat_t b;
        b.alu  = bus.alu_result;
        b.rd2  = bus.read_data_2;
        b.bt   = bus.branch_target;
        b.wreg = bus.write_reg;
        b.zf   = bus.zeroflag;
        b.br   = bus.branch;
        b.m2r  = bus.mem_to_reg;
        b.regw = bus.reg_write;
        b.memr = bus.mem_read;
        b.memw = bus.mem_write;
        return b;
    endfunction

    // Check current outputs against the model, advance the model by one edge.
    task automatic cyc();
        logic  acc, rel;
        beat_t tmp;
        #1;
        if (live) begin
            chk("occupancy", bus.occupancy, sb.size());
            chk("in_ready", bus.in_ready, sb.size() < 2);
            chk("out_valid", bus.out_valid, sb.size() != 0);
            chk("pcsrc", bus.pcsrc_ex_mem, exp_pc);
            if (sb.size() != 0) begin
                chk("alu_out", bus.alu_result_out, sb[0].alu);
                chk("rd2_out", bus.read_data_2_out, sb[0].rd2);
                chk("bt_out", bus.branch_target_out, sb[0].bt);
                chk("wreg_out", bus.write_reg_out, sb[0].wreg);
                chk("zf_out", bus.zeroflag_out, sb[0].zf);
                chk("br_out", bus.branch_out, sb[0].br);
                chk("m2r_out", bus.mem_to_reg_out, sb[0].m2r);
                chk("regw_out", bus.reg_write_out, sb[0].regw);
                chk("memr_out", bus.mem_read_out, sb[0].memr);
                chk("memw_out", bus.mem_write_out, sb[0].memw);
            end else begin
                chk("regw_gated", bus.reg_write_out, 0);
                chk("memr_gated", bus.mem_read_out, 0);
                chk("memw_gated", bus.mem_write_out, 0);
            end
        end
        rel = (sb.size() != 0) && bus.out_ready && bus.hit;
        acc = bus.in_valid && (sb.size() < 2) && bus.hit && !bus.flush;
        if (!rst_n) begin
            sb.delete();
            exp_pc = 1'b0;
            live   = 1'b1;
        end else if (bus.hit) begin
            if (rel) tmp = sb.pop_front();
            if (bus.flush) begin
                sb.delete();
                exp_pc = 1'b0;
            end else begin
                if (acc) sb.push_back(cur_beat());
                exp_pc = acc && tb_taken(bus.branch, bus.branch_type, bus.zeroflag);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [31:0] a, input logic br, input logic [1:0] bt,
                            input logic zf, input logic mw);
        bus.in_valid      = 1'b1;
        bus.alu_result    = a;
        bus.read_data_2   = a ^ 32'hdead_beef;
        bus.branch_target = a + 32'h400;
        bus.write_reg     = a[8:4];
        bus.zeroflag      = zf;
        bus.branch        = br;
        bus.branch_type   = bt;
        bus.mem_to_reg    = a[5];
        bus.reg_write     = 1'b1;
        bus.mem_read      = a[4];
        bus.mem_write     = mw;
    endtask

    task automatic send(input logic [31:0] a, input logic br, input logic [1:0] bt,
                        input logic zf, input logic mw);
        bit done;
        done = 1'b0;
        set_beat(a, br, bt, zf, mw);
        for (int t = 0; t < 20 && !done; t++) begin
            done = (sb.size() < 2) && bus.hit && !bus.flush;
            cyc();
        end
        if (!done) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic zero_checks(input string pfx);
        #1;
        chk({pfx, "_occ"}, bus.occupancy, 0);
        chk({pfx, "_valid"}, bus.out_valid, 0);
        chk({pfx, "_in_ready"}, bus.in_ready, 1);
        chk({pfx, "_pcsrc"}, bus.pcsrc_ex_mem, 0);
        chk({pfx, "_alu"}, bus.alu_result_out, 0);
        chk({pfx, "_rd2"}, bus.read_data_2_out, 0);
        chk({pfx, "_bt"}, bus.branch_target_out, 0);
        chk({pfx, "_wreg"}, bus.write_reg_out, 0);
        chk({pfx, "_ctl"}, {bus.zeroflag_out, bus.branch_out, bus.mem_to_reg_out,
                            bus.reg_write_out, bus.mem_read_out, bus.mem_write_out}, 0);
    endtask

    logic [3:0] br_tab [6];

    initial begin
        n_chk = 0; n_err = 0; live = 1'b0; exp_pc = 1'b0;
        // {branch, type[1:0], expected pcsrc}; zeroflag from the loop
        br_tab[0] = 4'b1_00_1; br_tab[1] = 4'b1_01_0; br_tab[2] = 4'b1_01_1;
        br_tab[3] = 4'b1_10_1; br_tab[4] = 4'b1_11_0; br_tab[5] = 4'b0_10_0;

        rst_n = 1'b0; bus.hit = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b0;
        set_beat(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        zero_checks("reset");

        // stream with the sink always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h10 * (i + 1), 1'b0, 2'b00, 1'b0, 1'b0);
            chk("stream_occ_le1", bus.occupancy <= 2'd1, 1);
        end
        idle(3);

        // backpressure: third beat waits at the input
        bus.out_ready = 1'b0;
        send(32'h10, 1'b0, 2'b00, 1'b0, 1'b1);
        send(32'h20, 1'b0, 2'b00, 1'b0, 1'b0);
        #1 chk("bp_in_ready_low", bus.in_ready, 0);
        set_beat(32'h30, 1'b0, 2'b00, 1'b0, 1'b1);
        repeat (3) cyc();
        bus.out_ready = 1'b1;
        send(32'h30, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(4);

        // freeze at full occupancy with a pending pcsrc pulse
        bus.out_ready = 1'b0;
        send(32'h50, 1'b0, 2'b00, 1'b0, 1'b0);
        send(32'h60, 1'b1, 2'b10, 1'b0, 1'b0);
        bus.hit = 1'b0;
        set_beat(32'h70, 1'b1, 2'b00, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        repeat (5) cyc();
        #1 chk("freeze_pcsrc_held", bus.pcsrc_ex_mem, 1);
        chk("freeze_occ_held", bus.occupancy, 2);
        bus.hit = 1'b1;
        idle(4);

        // branch decode, one beat at a time
        for (int k = 0; k < 6; k++) begin
            send(32'h100 + 32'(k), br_tab[k][3], br_tab[k][2:1], (k == 0 || k == 1), 1'b0);
            chk("br_decode", bus.pcsrc_ex_mem, br_tab[k][0]);
            idle(1);
        end
        idle(2);

        // flush at full occupancy drops held and incoming beats
        bus.out_ready = 1'b0;
        send(32'h200, 1'b0, 2'b00, 1'b0, 1'b1);
        send(32'h210, 1'b0, 2'b00, 1'b0, 1'b1);
        set_beat(32'h220, 1'b1, 2'b00, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_occ", bus.occupancy, 0);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_memw", bus.mem_write_out, 0);
        chk("flush_pcsrc", bus.pcsrc_ex_mem, 0);
        idle(3);

        // reset mid-operation overrides a freeze
        bus.out_ready = 1'b0;
        send(32'h300, 1'b0, 2'b00, 1'b0, 1'b1);
        send(32'h310, 1'b1, 2'b10, 1'b0, 1'b1);
        rst_n = 1'b0;
        bus.hit = 1'b0;
        cyc();
        zero_checks("midrst");
        rst_n = 1'b1;
        bus.hit = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
